// File: rtl/data_ram_responder_if.sv
// Data-SRAM request/response bundle between the execute stage and the responder.
interface data_ram_responder_if;
  logic        data_ram_enabled;
  logic [3:0]  data_ram_write_enabled;
  logic [31:0] data_ram_address;
  logic [31:0] data_ram_write_data;
  logic [31:0] data_ram_read_data;

  modport master (
    output data_ram_enabled,
    output data_ram_write_enabled,
    output data_ram_address,
    output data_ram_write_data,
    input  data_ram_read_data
  );

  modport slave (
    input  data_ram_enabled,
    input  data_ram_write_enabled,
    input  data_ram_address,
    input  data_ram_write_data,
    output data_ram_read_data
  );
endinterface

// File: rtl/data_ram_responder.sv
// Data-SRAM slave: byte-lane word RAM plus MMIO window (LED, timer, scratch).
// Read data is returned one cycle after the request.
module data_ram_responder #(
  parameter int unsigned WORD_ADDR_WIDTH = 14,
  parameter logic [31:0] MMIO_BASE       = 32'hbfaf_0000,
  parameter              INIT_FILE       = ""
) (
  input  logic                       clock,
  input  logic                       reset_n,
  data_ram_responder_if.slave        bus,
  output logic [15:0]                led
);

  localparam int unsigned DEPTH = 1 << WORD_ADDR_WIDTH;

  localparam logic [15:0] OFF_LED     = 16'h0000;
  localparam logic [15:0] OFF_TIMER   = 16'h0004;
  localparam logic [15:0] OFF_SCRATCH = 16'h0008;

  logic [31:0] mem [DEPTH];

  logic [31:0] read_data_q;
  logic [15:0] led_q,     led_d;
  logic [31:0] timer_q,   timer_d;
  logic [31:0] scratch_q, scratch_d;

  logic                       mmio_hit_c;
  logic [15:0]                offset_c;
  logic [WORD_ADDR_WIDTH-1:0] word_idx_c;
  logic                       wr_c;
  logic                       rd_c;
  logic [31:0]                mmio_rdata_c;

  // Overlay the strobed lanes of new data onto an existing word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Request decode: MMIO window vs aliased RAM word index.
  always_comb begin
    mmio_hit_c = (bus.data_ram_address[31:16] == MMIO_BASE[31:16]);
    offset_c   = bus.data_ram_address[15:0];
    word_idx_c = bus.data_ram_address[WORD_ADDR_WIDTH+1:2];
    wr_c       = bus.data_ram_enabled && (bus.data_ram_write_enabled != 4'h0);
    rd_c       = bus.data_ram_enabled && (bus.data_ram_write_enabled == 4'h0);
  end

  // MMIO read mux; unmapped offsets read as zero.
  always_comb begin
    mmio_rdata_c = 32'h0;
    case (offset_c)
      OFF_LED:     mmio_rdata_c = {16'h0, led_q};
      OFF_TIMER:   mmio_rdata_c = timer_q;
      OFF_SCRATCH: mmio_rdata_c = scratch_q;
      default:     mmio_rdata_c = 32'h0;
    endcase
  end

  // MMIO register next state; a timer write replaces that cycle's increment.
  always_comb begin
    led_d     = led_q;
    timer_d   = timer_q + 32'd1;
    scratch_d = scratch_q;
    if (wr_c && mmio_hit_c) begin
      case (offset_c)
        OFF_LED: begin
          if (bus.data_ram_write_enabled[0]) led_d[7:0]  = bus.data_ram_write_data[7:0];
          if (bus.data_ram_write_enabled[1]) led_d[15:8] = bus.data_ram_write_data[15:8];
        end
        OFF_TIMER:   timer_d   = merge_lanes(timer_q, bus.data_ram_write_data,
                                             bus.data_ram_write_enabled);
        OFF_SCRATCH: scratch_d = merge_lanes(scratch_q, bus.data_ram_write_data,
                                             bus.data_ram_write_enabled);
        default: ;
      endcase
    end
  end

  // RAM byte-lane writes; contents are not reset.
  always_ff @(posedge clock) begin
    if (wr_c && !mmio_hit_c) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_ram_write_enabled[i])
          mem[word_idx_c][8*i +: 8] <= bus.data_ram_write_data[8*i +: 8];
      end
    end
  end

  // Registered read data, updated only by read requests.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_data_q <= 32'h0;
    end else if (rd_c) begin
      read_data_q <= mmio_hit_c ? mmio_rdata_c : mem[word_idx_c];
    end
  end

  // MMIO register state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led_q     <= 16'h0;
      timer_q   <= 32'h0;
      scratch_q <= 32'h0;
    end else begin
      led_q     <= led_d;
      timer_q   <= timer_d;
      scratch_q <= scratch_d;
    end
  end

  assign bus.data_ram_read_data = read_data_q;
  assign led                    = led_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed self-checking bench for data_ram_responder.
module tb_data_ram_responder;

  logic        clock;
  logic        reset_n;
  logic [15:0] led;
  int          n_checks;
  int          n_fail;

  data_ram_responder_if bus();

  data_ram_responder #(
    .WORD_ADDR_WIDTH(14),
    .MMIO_BASE      (32'hbfaf_0000),
    .INIT_FILE      ("")
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus),
    .led    (led)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one request at the falling edge, let it be sampled, settle 1 time unit.
  task automatic req(input logic en, input logic [3:0] wen,
                     input logic [31:0] addr, input logic [31:0] data);
    @(negedge clock);
    bus.data_ram_enabled       = en;
    bus.data_ram_write_enabled = wen;
    bus.data_ram_address       = addr;
    bus.data_ram_write_data    = data;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    reset_n                    = 1'b0;
    bus.data_ram_enabled       = 1'b0;
    bus.data_ram_write_enabled = 4'h0;
    bus.data_ram_address       = 32'h0;
    bus.data_ram_write_data    = 32'h0;
    #12;
    n_checks++;
    if (bus.data_ram_read_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata got=%h exp=%h", bus.data_ram_read_data, 32'h0);
    end
    n_checks++;
    if (led !== 16'h0) begin
      n_fail++; $display("FAIL reset_led got=%h exp=%h", led, 16'h0);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_word_rw();
    req(1'b1, 4'hf, 32'h0000_0010, 32'hdead_beef);
    req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    n_checks++;
    if (bus.data_ram_read_data !== 32'hdead_beef) begin
      n_fail++; $display("FAIL word_rw got=%h exp=%h", bus.data_ram_read_data, 32'hdead_beef);
    end
    // Writes and idle cycles must leave read data untouched.
    req(1'b1, 4'hf, 32'h0000_0018, 32'h0bad_f00d);
    idle();
    n_checks++;
    if (bus.data_ram_read_data !== 32'hdead_beef) begin
      n_fail++; $display("FAIL rdata_hold got=%h exp=%h", bus.data_ram_read_data, 32'hdead_beef);
    end
  endtask

  task automatic test_byte_lanes();
    req(1'b1, 4'hf, 32'h0000_0014, 32'h1122_3344);
    req(1'b1, 4'b0100, 32'h0000_0014, 32'h00aa_0000);
    req(1'b1, 4'h0, 32'h0000_0014, 32'h0);
    n_checks++;
    if (bus.data_ram_read_data !== 32'h11aa_3344) begin
      n_fail++; $display("FAIL byte_lane2 got=%h exp=%h", bus.data_ram_read_data, 32'h11aa_3344);
    end
    // Address bits [1:0] are ignored; lanes come from the strobes.
    req(1'b1, 4'b1001, 32'h0000_0017, 32'h55ff_ff66);
    req(1'b1, 4'h0, 32'h0000_0014, 32'h0);
    n_checks++;
    if (bus.data_ram_read_data !== 32'h55aa_3366) begin
      n_fail++; $display("FAIL byte_lane03 got=%h exp=%h", bus.data_ram_read_data, 32'h55aa_3366);
    end
  endtask

  task automatic test_alias();
    req(1'b1, 4'hf, 32'h0001_0020, 32'hcafe_f00d);
    req(1'b1, 4'h0, 32'h0000_0020, 32'h0);
    n_checks++;
    if (bus.data_ram_read_data !== 32'hcafe_f00d) begin
      n_fail++; $display("FAIL alias_low got=%h exp=%h", bus.data_ram_read_data, 32'hcafe_f00d);
    end
    req(1'b1, 4'h0, 32'h7ff3_0020, 32'h0);
    n_checks++;
    if (bus.data_ram_read_data !== 32'hcafe_f00d) begin
      n_fail++; $display("FAIL alias_high got=%h exp=%h", bus.data_ram_read_data, 32'hcafe_f00d);
    end
  endtask

  task automatic test_mmio();
    req(1'b1, 4'hf, 32'hbfaf_0000, 32'h1234_5678);
    n_checks++;
    if (led !== 16'h5678) begin
      n_fail++; $display("FAIL led_out got=%h exp=%h", led, 16'h5678);
    end
    req(1'b1, 4'h0, 32'hbfaf_0000, 32'h0);
    n_checks++;
    if (bus.data_ram_read_data !== 32'h0000_5678) begin
      n_fail++; $display("FAIL led_read got=%h exp=%h", bus.data_ram_read_data, 32'h0000_5678);
    end
    req(1'b1, 4'hf, 32'hbfaf_0008, 32'ha5a5_5a5a);
    req(1'b1, 4'b0010, 32'hbfaf_0008, 32'h0000_3c00);
    req(1'b1, 4'h0, 32'hbfaf_0008, 32'h0);
    n_checks++;
    if (bus.data_ram_read_data !== 32'ha5a5_3c5a) begin
      n_fail++; $display("FAIL scratch got=%h exp=%h", bus.data_ram_read_data, 32'ha5a5_3c5a);
    end
    req(1'b1, 4'hf, 32'hbfaf_000c, 32'hffff_ffff);
    req(1'b1, 4'h0, 32'hbfaf_000c, 32'h0);
    n_checks++;
    if (bus.data_ram_read_data !== 32'h0) begin
      n_fail++; $display("FAIL unmapped got=%h exp=%h", bus.data_ram_read_data, 32'h0);
    end
    // MMIO write must not disturb the aliased RAM word 0.
    req(1'b1, 4'hf, 32'h0000_0000, 32'h0102_0304);
    req(1'b1, 4'hf, 32'hbfaf_0000, 32'h0000_9999);
    req(1'b1, 4'h0, 32'h0000_0000, 32'h0);
    n_checks++;
    if (bus.data_ram_read_data !== 32'h0102_0304) begin
      n_fail++; $display("FAIL mmio_ram_iso got=%h exp=%h", bus.data_ram_read_data, 32'h0102_0304);
    end
  endtask

  task automatic test_timer();
    req(1'b1, 4'hf, 32'hbfaf_0004, 32'hffff_fffe);
    req(1'b1, 4'h0, 32'hbfaf_0004, 32'h0);
    n_checks++;
    if (bus.data_ram_read_data !== 32'hffff_fffe) begin
      n_fail++; $display("FAIL timer_t1 got=%h exp=%h", bus.data_ram_read_data, 32'hffff_fffe);
    end
    req(1'b1, 4'h0, 32'hbfaf_0004, 32'h0);
    n_checks++;
    if (bus.data_ram_read_data !== 32'hffff_ffff) begin
      n_fail++; $display("FAIL timer_t2 got=%h exp=%h", bus.data_ram_read_data, 32'hffff_ffff);
    end
    req(1'b1, 4'h0, 32'hbfaf_0004, 32'h0);
    n_checks++;
    if (bus.data_ram_read_data !== 32'h0) begin
      n_fail++; $display("FAIL timer_wrap got=%h exp=%h", bus.data_ram_read_data, 32'h0);
    end
    // Lane write merges over current value: timer is 1 here, becomes 0x0000_7701.
    req(1'b1, 4'b0010, 32'hbfaf_0004, 32'h0000_7700);
    idle();
    idle();
    req(1'b1, 4'h0, 32'hbfaf_0004, 32'h0);
    n_checks++;
    if (bus.data_ram_read_data !== 32'h0000_7703) begin
      n_fail++; $display("FAIL timer_merge got=%h exp=%h", bus.data_ram_read_data, 32'h0000_7703);
    end
  endtask

  task automatic test_back_to_back();
    req(1'b1, 4'hf, 32'h0000_0030, 32'h1357_9bdf);
    req(1'b1, 4'h0, 32'h0000_0030, 32'h0);
    n_checks++;
    if (bus.data_ram_read_data !== 32'h1357_9bdf) begin
      n_fail++; $display("FAIL raw got=%h exp=%h", bus.data_ram_read_data, 32'h1357_9bdf);
    end
    req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    n_checks++;
    if (bus.data_ram_read_data !== 32'hdead_beef) begin
      n_fail++; $display("FAIL b2b_read got=%h exp=%h", bus.data_ram_read_data, 32'hdead_beef);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    bus.data_ram_enabled       = 1'b1;
    bus.data_ram_write_enabled = 4'h0;
    bus.data_ram_address       = 32'h0000_0014;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.data_ram_read_data !== 32'h0) begin
      n_fail++; $display("FAIL midreset_rdata got=%h exp=%h", bus.data_ram_read_data, 32'h0);
    end
    n_checks++;
    if (led !== 16'h0) begin
      n_fail++; $display("FAIL midreset_led got=%h exp=%h", led, 16'h0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    n_checks++;
    if (bus.data_ram_read_data !== 32'hdead_beef) begin
      n_fail++; $display("FAIL ram_retained got=%h exp=%h", bus.data_ram_read_data, 32'hdead_beef);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_alias();
    test_mmio();
    test_timer();
    test_back_to_back();
    test_reset_mid();
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
